imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit words
// and writes them to consecutive word addresses, keeping a count and an XOR checksum.
module imem_loader #(
    parameter int unsigned COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        base_addr,
    input  logic [COUNT_W-1:0] word_count,
    input  logic               in_valid,
    input  logic [7:0]         in_byte,
    output logic               in_ready,
    output logic               imem_we,
    output logic [31:0]        imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] words_written,
    output logic [31:0]        checksum
);

    typedef enum logic [1:0] {
        StIdle,
        StRecv,
        StWrite,
        StDone
    } state_e;

    state_e             state_q;
    logic [31:0]        base_q;
    logic [COUNT_W-1:0] count_q;
    logic [1:0]         byte_idx_q;
    logic [23:0]        asm_q;

    logic [COUNT_W-1:0] words_next;
    logic [31:0]        word_offset;

    // words_written stays below count_q until the final write, so the increment never wraps.
    assign words_next  = words_written + COUNT_W'(1);
    assign word_offset = 32'(words_written) << 2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            base_q        <= '0;
            count_q       <= '0;
            byte_idx_q    <= '0;
            asm_q         <= '0;
            in_ready      <= 1'b0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            checksum      <= '0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q        <= base_addr & 32'hFFFF_FFFC;
                        count_q       <= word_count;
                        words_written <= '0;
                        checksum      <= '0;
                        byte_idx_q    <= '0;
                        asm_q         <= '0;
                        if (word_count == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q  <= StRecv;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                StRecv: begin
                    // in_ready is high throughout this state, so in_valid alone marks a handshake.
                    if (in_valid) begin
                        unique case (byte_idx_q)
                            2'd0: asm_q[7:0]   <= in_byte;
                            2'd1: asm_q[15:8]  <= in_byte;
                            2'd2: asm_q[23:16] <= in_byte;
                            default: begin
                                imem_wdata <= {in_byte, asm_q};
                                imem_addr  <= base_q + word_offset;
                                imem_we    <= 1'b1;
                                in_ready   <= 1'b0;
                                state_q    <= StWrite;
                            end
                        endcase
                        byte_idx_q <= byte_idx_q + 2'd1;
                    end
                end
                StWrite: begin
                    words_written <= words_next;
                    checksum      <= checksum ^ imem_wdata;
                    if (words_next == count_q) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        state_q  <= StRecv;
                        in_ready <= 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
